bus_dma: RTL

Word-copy DMA engine for the miniRV SoC data bus. It has two ports. A responder port is addressed by the Bridge like Led and Dig, and the CPU uses it to program source, destination and length. An initiator port drives the same addr/we/wdata/rdata protocol the CPU uses toward the Bridge. An SoC-level mux grants the initiator port in cycles where the single-cycle CPU is not issuing a load or store. The engine moves LEN words from SRC to DST, one read and one write per word.

---
 rtl/bus_dma.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bus_dma.sv
// Word-copy DMA engine: a responder register block (SRC/DST/LEN/CTRL) and an
// initiator port that moves LEN words from SRC to DST, one read then one write per word.
module bus_dma (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic [31:0] addr_from_bg,
    input  logic        we_from_bg,
    input  logic [31:0] wdata_from_bg,
    output logic [31:0] rdata_to_bg,
    output logic        dma_req,
    input  logic        dma_gnt,
    output logic [31:0] dma_addr,
    output logic        dma_we,
    output logic [31:0] dma_wdata,
    input  logic [31:0] dma_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_e;

    localparam logic [1:0] SEL_SRC  = 2'd0;
    localparam logic [1:0] SEL_DST  = 2'd1;
    localparam logic [1:0] SEL_LEN  = 2'd2;
    localparam logic [1:0] SEL_CTRL = 2'd3;

    state_e      state_q, state_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [15:0] len_q, len_d;
    logic        done_q, done_d;
    logic [31:0] cur_src_q, cur_src_d;
    logic [31:0] cur_dst_q, cur_dst_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] buf_q, buf_d;

    logic [1:0]  reg_sel;
    logic        busy;
    logic        start;
    logic        abort;
    logic        unused_addr_bits;

    assign reg_sel          = addr_from_bg[3:2];
    assign busy             = (state_q != IDLE);
    assign start            = we_from_bg && (reg_sel == SEL_CTRL) && wdata_from_bg[0];
    assign abort            = we_from_bg && (reg_sel == SEL_CTRL) && wdata_from_bg[1];
    assign unused_addr_bits = ^{addr_from_bg[31:4], addr_from_bg[1:0]};

    // NOTE: every _d gets its hold value first so no path through the
    // case statements can leave a variable unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        done_d    = done_q;
        cur_src_d = cur_src_q;
        cur_dst_d = cur_dst_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;

        // Programmed registers are frozen for the whole transfer.
        if (we_from_bg && !busy) begin
            case (reg_sel)
                SEL_SRC: src_d = {wdata_from_bg[31:2], 2'b00};
                SEL_DST: dst_d = {wdata_from_bg[31:2], 2'b00};
                SEL_LEN: len_d = wdata_from_bg[15:0];
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    done_d = (len_q == 16'd0);
                    if (len_q != 16'd0) begin
                        state_d   = RD;
                        cur_src_d = src_q;
                        cur_dst_d = dst_q;
                        cnt_d     = len_q;
                    end
                end
            end
            RD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (dma_gnt) begin
                    buf_d   = dma_rdata;
                    state_d = WR;
                end
            end
            WR: begin
                // A granted write completes on the bus even if abort arrives with it.
                if (dma_gnt) begin
                    cur_src_d = cur_src_q + 32'd4;
                    cur_dst_d = cur_dst_q + 32'd4;
                    cnt_d     = cnt_q - 16'd1;
                end
                if (abort) begin
                    state_d = IDLE;
                end else if (dma_gnt) begin
                    if (cnt_q == 16'd1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dma_req   = busy;
        dma_we    = (state_q == WR) && dma_gnt;
        dma_wdata = buf_q;
        case (state_q)
            RD:      dma_addr = cur_src_q;
            WR:      dma_addr = cur_dst_q;
            default: dma_addr = 32'd0;
        endcase
    end

    always_comb begin
        case (reg_sel)
            SEL_SRC: rdata_to_bg = src_q;
            SEL_DST: rdata_to_bg = dst_q;
            SEL_LEN: rdata_to_bg = {16'd0, len_q};
            default: rdata_to_bg = {30'd0, done_q, busy};
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others regardless of statement order.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q   <= IDLE;
            src_q     <= 32'd0;
            dst_q     <= 32'd0;
            len_q     <= 16'd0;
            done_q    <= 1'b0;
            cur_src_q <= 32'd0;
            cur_dst_q <= 32'd0;
            cnt_q     <= 16'd0;
            buf_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            done_q    <= done_d;
            cur_src_q <= cur_src_d;
            cur_dst_q <= cur_dst_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
        end
    end

endmodule
